// File: rtl/jt51_noise_gen_if.sv
// Signal bundle for jt51_noise_gen.
// Parameters W, DIVW and SW must match the attached generator instance.
//   cen     : phase enable from the chip clock divider
//   nen     : noise run enable
//   nfrq    : frequency code, larger is faster
//   seed_wr : one-clk seed load strobe
//   seed    : value loaded on seed_wr
//   out     : noise bit (LFSR MSB)
//   sample  : top SW bits of the LFSR
//   step    : one-clk pulse aligned with each new LFSR value
//   lock    : sticky flag, set when lock-up recovery has occurred
interface jt51_noise_gen_if #(
  parameter int unsigned W    = 17,
  parameter int unsigned DIVW = 5,
  parameter int unsigned SW   = 4
);
  logic            cen;
  logic            nen;
  logic [DIVW-1:0] nfrq;
  logic            seed_wr;
  logic [W-1:0]    seed;
  logic            out;
  logic [SW-1:0]   sample;
  logic            step;
  logic            lock;

  // Controller side: drives the controls, observes the noise outputs.
  modport master (
    output cen, nen, nfrq, seed_wr, seed,
    input  out, sample, step, lock
  );

  // Generator side.
  modport slave (
    input  cen, nen, nfrq, seed_wr, seed,
    output out, sample, step, lock
  );
endinterface

// File: rtl/jt51_noise_gen.sv
// Programmable-rate XNOR LFSR noise generator.
// Ports:
//   clk : chip clock
//   rst : asynchronous, active-high reset
//   nif : jt51_noise_gen_if slave (cen, nen, nfrq, seed_wr, seed in;
//         out, sample, step, lock out)
// The divider counts qualifying cen ticks and shifts the LFSR every
// 2^DIVW - nfrq ticks. The all-ones state (the XNOR lock-up) is replaced by
// INIT at the next shift and flagged on the sticky lock output.
module jt51_noise_gen #(
  parameter int unsigned W     = 17,
  parameter int unsigned TAP_A = 16,
  parameter int unsigned TAP_B = 13,
  parameter int unsigned INIT  = 14220,
  parameter int unsigned DIVW  = 5,
  parameter int unsigned SW    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  jt51_noise_gen_if.slave      nif
);

  localparam logic [W-1:0]    InitVal = W'(INIT);
  localparam logic [DIVW-1:0] CntOne  = DIVW'(1);

  logic [W-1:0]    bb_q,   bb_d;
  logic [DIVW-1:0] cnt_q,  cnt_d;
  logic            step_q, step_d;
  logic            lock_q, lock_d;

  logic            run;
  logic            term;
  logic            locked_up;
  logic            fb;
  logic [W-1:0]    bb_shift;

  assign run       = nif.cen & nif.nen;
  // Using >= rather than == lets a lowered nfrq terminate on the next cen
  // instead of wrapping the counter through 2^DIVW.
  assign term      = run & (cnt_q >= ~nif.nfrq);
  assign locked_up = &bb_q;
  assign fb        = ~(bb_q[TAP_A] ^ bb_q[TAP_B]);
  assign bb_shift  = {bb_q[W-2:0], fb};

  always_comb begin
    bb_d   = bb_q;
    cnt_d  = cnt_q;
    lock_d = lock_q;
    step_d = term;
    if (nif.seed_wr) begin
      // Seed load wins over a coincident shift; an all-ones seed is kept
      // and recovered at the following shift.
      bb_d   = nif.seed;
      cnt_d  = '0;
      lock_d = 1'b0;
      step_d = 1'b0;
    end else if (term) begin
      cnt_d = '0;
      if (locked_up) begin
        bb_d   = InitVal;
        lock_d = 1'b1;
      end else begin
        bb_d = bb_shift;
      end
    end else if (run) begin
      cnt_d = cnt_q + CntOne;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bb_q   <= InitVal;
      cnt_q  <= '0;
      step_q <= 1'b0;
      lock_q <= 1'b0;
    end else begin
      bb_q   <= bb_d;
      cnt_q  <= cnt_d;
      step_q <= step_d;
      lock_q <= lock_d;
    end
  end

  assign nif.out    = bb_q[W-1];
  assign nif.sample = bb_q[W-1 -: SW];
  assign nif.step   = step_q;
  assign nif.lock   = lock_q;

endmodule

// File: tb/tb_jt51_noise_gen.sv
module tb_jt51_noise_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  jt51_noise_gen_if #(.W(17), .DIVW(5), .SW(4)) nif ();

  jt51_noise_gen #(
    .W(17), .TAP_A(16), .TAP_B(13), .INIT(14220), .DIVW(5), .SW(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .nif (nif.slave)
  );

  typedef struct {
    logic        cen;
    logic        nen;
    logic [4:0]  nfrq;
    logic        seed_wr;
    logic [16:0] seed;
    logic [16:0] exp_bb;
    logic        exp_step;
    logic        exp_lock;
    logic [4:0]  exp_cnt;
  } vec_t;

  int   nvec = 0;
  int   nmis = 0;
  bit   mode3 = 1'b0;
  int   phase = 0;
  vec_t tbl[13];

  function automatic logic [16:0] lfsr_ref(input logic [16:0] s);
    if (s == 17'h1FFFF) return 17'h0378C;
    return {s[15:0], ~(s[16] ^ s[13])};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clk: set cen per pattern, take the edge, sample 1 time unit later.
  task automatic tick();
    if (mode3) begin
      nif.cen = (phase == 0);
      phase   = (phase + 1) % 3;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_step(input int maxc, output int n);
    n = 0;
    for (int i = 0; i < maxc; i++) begin
      tick();
      n++;
      if (nif.step === 1'b1) break;
    end
  endtask

  task automatic load_seed(input logic [16:0] s);
    nif.seed_wr = 1'b1;
    nif.seed    = s;
    tick();
    nif.seed_wr = 1'b0;
  endtask

  initial begin
    int n;
    int steps;
    logic [16:0] m;

    //          cen  nen  nfrq seed_wr seed      exp_bb    step lock cnt
    tbl[0]  = '{1'b1, 1'b1, 5'd31, 1'b0, 17'h0,     17'h06F18, 1'b1, 1'b0, 5'd0};
    tbl[1]  = '{1'b1, 1'b1, 5'd31, 1'b0, 17'h0,     17'h0DE30, 1'b1, 1'b0, 5'd0};
    tbl[2]  = '{1'b1, 1'b1, 5'd31, 1'b0, 17'h0,     17'h1BC61, 1'b1, 1'b0, 5'd0};
    tbl[3]  = '{1'b1, 1'b1, 5'd31, 1'b0, 17'h0,     17'h178C3, 1'b1, 1'b0, 5'd0};
    tbl[4]  = '{1'b0, 1'b1, 5'd31, 1'b0, 17'h0,     17'h178C3, 1'b0, 1'b0, 5'd0};
    tbl[5]  = '{1'b1, 1'b0, 5'd31, 1'b0, 17'h0,     17'h178C3, 1'b0, 1'b0, 5'd0};
    tbl[6]  = '{1'b1, 1'b1, 5'd31, 1'b1, 17'h1FFFF, 17'h1FFFF, 1'b0, 1'b0, 5'd0};
    tbl[7]  = '{1'b1, 1'b1, 5'd31, 1'b0, 17'h0,     17'h0378C, 1'b1, 1'b1, 5'd0};
    tbl[8]  = '{1'b1, 1'b1, 5'd31, 1'b0, 17'h0,     17'h06F18, 1'b1, 1'b1, 5'd0};
    tbl[9]  = '{1'b0, 1'b1, 5'd31, 1'b1, 17'h00001, 17'h00001, 1'b0, 1'b0, 5'd0};
    tbl[10] = '{1'b1, 1'b1, 5'd30, 1'b0, 17'h0,     17'h00001, 1'b0, 1'b0, 5'd1};
    tbl[11] = '{1'b1, 1'b1, 5'd30, 1'b0, 17'h0,     17'h00003, 1'b1, 1'b0, 5'd0};
    tbl[12] = '{1'b1, 1'b1, 5'd31, 1'b1, 17'h0ABCD, 17'h0ABCD, 1'b0, 1'b0, 5'd0};

    nif.cen = 1'b0; nif.nen = 1'b0; nif.nfrq = '0; nif.seed_wr = 1'b0; nif.seed = '0;
    #12;
    chk("rst_bb",     32'(dut.bb_q), 32'h0378C);
    chk("rst_cnt",    32'(dut.cnt_q), 32'd0);
    chk("rst_out",    32'(nif.out), 32'd0);
    chk("rst_sample", 32'(nif.sample), 32'b0001);
    chk("rst_step",   32'(nif.step), 32'd0);
    chk("rst_lock",   32'(nif.lock), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed vector table, one clk each.
    for (int i = 0; i < 13; i++) begin
      nif.cen = tbl[i].cen; nif.nen = tbl[i].nen; nif.nfrq = tbl[i].nfrq;
      nif.seed_wr = tbl[i].seed_wr; nif.seed = tbl[i].seed;
      tick();
      chk($sformatf("v%0d_bb", i),     32'(dut.bb_q), 32'(tbl[i].exp_bb));
      chk($sformatf("v%0d_sample", i), 32'(nif.sample), 32'(tbl[i].exp_bb[16:13]));
      chk($sformatf("v%0d_step", i),   32'(nif.step), 32'(tbl[i].exp_step));
      chk($sformatf("v%0d_lock", i),   32'(nif.lock), 32'(tbl[i].exp_lock));
      chk($sformatf("v%0d_cnt", i),    32'(dut.cnt_q), 32'(tbl[i].exp_cnt));
    end
    nif.seed_wr = 1'b0;

    // 1000 shifts at full rate against the reference LFSR.
    m = 17'h0ABCD;
    nif.cen = 1'b1; nif.nen = 1'b1; nif.nfrq = 5'd31;
    for (int i = 0; i < 1000; i++) begin
      tick();
      m = lfsr_ref(m);
      chk($sformatf("seq%0d_bb", i), 32'(dut.bb_q), 32'(m));
      chk($sformatf("seq%0d_out", i), 32'(nif.out), 32'(m[16]));
    end

    // Seed load coincident with term discards the shift; next step a full period later.
    nif.nfrq = 5'd28;
    load_seed(17'h12345);
    wait_step(50, n);
    chk("p4_first", 32'(n), 32'd4);
    tick(); tick(); tick();
    chk("p4_cnt3", 32'(dut.cnt_q), 32'd3);
    load_seed(17'h00F0F);
    chk("seedterm_bb",   32'(dut.bb_q), 32'h00F0F);
    chk("seedterm_step", 32'(nif.step), 32'd0);
    chk("seedterm_cnt",  32'(dut.cnt_q), 32'd0);
    wait_step(50, n);
    chk("seedterm_next", 32'(n), 32'd4);

    // nen=0 freezes divider and LFSR; counting resumes from the held count.
    nif.nfrq = 5'd0;
    load_seed(17'h05555);
    for (int i = 0; i < 7; i++) tick();
    chk("hold_cnt_pre", 32'(dut.cnt_q), 32'd7);
    nif.nen = 1'b0;
    steps = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (nif.step === 1'b1) steps++;
    end
    chk("hold_steps", 32'(steps), 32'd0);
    chk("hold_cnt",   32'(dut.cnt_q), 32'd7);
    chk("hold_bb",    32'(dut.bb_q), 32'h05555);
    nif.nen = 1'b1;
    wait_step(100, n);
    chk("hold_resume", 32'(n), 32'd25);
    chk("hold_resume_bb", 32'(dut.bb_q), 32'(lfsr_ref(17'h05555)));

    // Slow rate with cen one clk in three, then a mid-count nfrq change.
    nif.cen = 1'b0;
    load_seed(17'h0378C);
    mode3 = 1'b1; phase = 0;
    wait_step(200, n);
    chk("div3_first", 32'(n), 32'd94);
    wait_step(200, n);
    chk("div3_period", 32'(n), 32'd96);
    steps = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (nif.step === 1'b1) steps++;
    end
    chk("div3_nostep", 32'(steps), 32'd0);
    chk("div3_cnt10",  32'(dut.cnt_q), 32'd10);
    nif.nfrq = 5'd28;
    wait_step(50, n);
    chk("nfrq_drop_next", 32'(n), 32'd3);
    wait_step(50, n);
    chk("nfrq_drop_period", 32'(n), 32'd12);

    // Reset pulsed mid-period clears state without waiting for an edge.
    mode3 = 1'b0; nif.cen = 1'b1; nif.nfrq = 5'd0;
    load_seed(17'h1FFFF);
    nif.nfrq = 5'd31;
    tick();
    chk("lock_set", 32'(nif.lock), 32'd1);
    nif.nfrq = 5'd0;
    tick(); tick(); tick();
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_bb",     32'(dut.bb_q), 32'h0378C);
    chk("mid_rst_cnt",    32'(dut.cnt_q), 32'd0);
    chk("mid_rst_step",   32'(nif.step), 32'd0);
    chk("mid_rst_lock",   32'(nif.lock), 32'd0);
    chk("mid_rst_sample", 32'(nif.sample), 32'b0001);
    @(negedge clk);
    rst = 1'b0;
    wait_step(100, n);
    chk("post_rst_first", 32'(n), 32'd32);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/jt51_noise_gen.md
# jt51_noise_gen

Parametrised noise generator and successor to the fixed 17-bit noise LFSR. Adds a programmable period divider (NFRQ-style), run/stop enable, software seed load, multi-bit sample output, an advance strobe, and automatic recovery from the XNOR lock-up state. It sits in the operator/noise path, clocked by the chip clock with the same `cen` phase enable as the envelope and phase generators.

## Interface
Parameters:
- `W`, default 17: LFSR width. Legal range 4..32.
- `TAP_A`, default 16: first XNOR tap index. Must be less than W.
- `TAP_B`, default 13: second XNOR tap index. Must be less than W and different from TAP_A.
- `INIT`, default 14220: reset and recovery state, `INIT[W-1:0]`. Must not be all ones.
- `DIVW`, default 5: width of the divider and of `nfrq`.
- `SW`, default 4: sample width. Legal range 1..W.

Ports:
- `rst` in 1: reset, asynchronous, active-high.
- `clk` in 1: clock.
- `cen` in 1: clock enable; the divider advances only on edges where `cen` is 1.
- `nen` in 1: noise run enable; when 0, the divider and LFSR hold.
- `nfrq` in DIVW: frequency code; larger value gives a higher rate.
- `seed_wr` in 1: load strobe, one clk wide, not gated by `cen`.
- `seed` in W: value loaded on `seed_wr`.
- `out` out 1: noise bit, `bb[W-1]`.
- `sample` out SW: `bb[W-1 -: SW]`.
- `step` out 1: registered one-clk pulse marking an LFSR advance.
- `lock` out 1: sticky flag, set when lock-up recovery has occurred.

## Operation
- State: `bb[W-1:0]` is the LFSR; `cnt[DIVW-1:0]` is the divider.
- Terminal condition: `term = cen & nen & (cnt >= ~nfrq)`. The comparison is unsigned DIVW-bit.
- Shift period is `2^DIVW - nfrq` cen ticks. With `nfrq` all ones the LFSR shifts on every cen; with `nfrq=0` it shifts every 32 cen (DIVW=5).
- Divider:
  - On `cen & nen & !term`: `cnt <= cnt+1`.
  - On `term`: `cnt <= 0`.
  - Otherwise `cnt` holds.
  - Using `>=` means a decrease of `nfrq` that leaves `cnt` above the new terminal value terminates on the next cen. It does not wrap through 2^DIVW.
- Shift on `term`:
  - If `bb` is all ones (the XNOR lock-up state): `bb <= INIT`, `lock <= 1`.
  - Otherwise: `bb <= {bb[W-2:0], ~(bb[TAP_A]^bb[TAP_B])}`.
- `step <= term`, evaluated on every clk edge. It is therefore 0 on edges where `cen` is 0.
- Seed load, `seed_wr=1`, has priority over everything except reset:
  - `bb <= seed`, `cnt <= 0`, `lock <= 0`, `step <= 0`.
  - Any coincident `term` is discarded.
  - An all-ones seed is accepted as written and is recovered at the next shift.
- `nen=0`: `cnt` and `bb` hold and `step` is 0. `seed_wr` still works.
- Changes to `nfrq` take effect on the next cen edge. No resynchronisation is applied.

## Timing
- Reset values: `bb=INIT`, `cnt=0`, `step=0`, `lock=0`. Hence `out=INIT[W-1]` and `sample=INIT[W-1 -: SW]`.
- `out` and `sample` are direct register bits. A new value is visible the clk after the shift edge.
- `step` is high for exactly one clk, in the cycle after the shifting edge, aligned with the new `bb`.
- `seed_wr` latency: `bb=seed` in the cycle after the strobe edge.
- First shift after reset or seed occurs on the `(2^DIVW - nfrq)`-th qualifying cen edge.
- Reset asserted mid-count clears all state immediately (asynchronously). Operation restarts from `cnt=0` after release.

## Test plan
- Reset with defaults (W=17, SW=4) -> `out=0`, `sample=4'b0001`, `step=0`, `lock=0`, `bb=17'h0378C`.
- `nfrq=31`, `nen=1`, `cen` always 1 -> `step` is 1 every clk. After the first step `bb=17'h06F18`. A 1000-shift bit sequence matches a reference model.
- `nfrq=0`, `cen` one clk in 3 -> `step` period is 32 cen = 96 clk. Change `nfrq` to 28 when `cnt=10` -> step on the next cen, then every 4 cen.
- `seed_wr` with `seed=17'h1FFFF`, then one shift -> `bb=17'h0378C`, `lock=1`. A later `seed_wr` clears `lock`.
- `seed_wr` on the same edge as `term` -> `bb=seed`, `cnt=0`, `step=0`. The next step comes a full period later.
- `nen=0` for 50 cen, then 1 -> no `step`, `bb` and `cnt` frozen. Counting resumes from the held `cnt`. Reset pulsed mid-period -> all reset values within the same cycle.
